// File: rtl/cache_axi_winterface.sv
// D-cache dirty-line writeback initiator: one INCR burst per request on AXI AW/W/B.
// Optional sticky error output wb_err when CACHE_AXI_WB_ERR_EN is defined.
module cache_axi_winterface #(
    parameter int          LINE_WORDS = 16,
    parameter logic [3:0]  AXI_ID     = 4'd1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             wb_addr,
    input  logic [LINE_WORDS*32-1:0] wb_line,
    input  logic                    wb_req,
    output logic                    wb_ack,
    output logic                    wb_busy,
    output logic                    wb_done,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic [1:0]              awlock,
    output logic [3:0]              awcache,
    output logic [2:0]              awprot,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [3:0]              wid,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
`ifdef CACHE_AXI_WB_ERR_EN
    ,
    output logic                    wb_err
`endif
);

    localparam int OFS = $clog2(LINE_WORDS * 4);
    localparam int IW  = $clog2(LINE_WORDS);
    localparam int BW  = IW + 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [31:0]     addr_q;
    logic [31:0]     buf_q [LINE_WORDS];
    logic            accept;
    logic            last_beat;
    logic            unused_inputs;

    assign accept    = (state_q == IDLE) && wb_req;
    assign last_beat = (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Line buffer lets d$ reuse the victim way right after wb_ack.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= {wb_addr[31:OFS], {OFS{1'b0}}};
            for (int i = 0; i < LINE_WORDS; i++) begin
                buf_q[i] <= wb_line[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        wb_ack  = 1'b0;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        wb_done = 1'b0;
        case (state_q)
            IDLE: begin
                wb_ack = wb_req;
                if (wb_req) state_d = ADDR;
            end
            ADDR: begin
                awvalid = 1'b1;
                if (awready) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                wvalid = 1'b1;
                if (wready) begin
                    beat_d = beat_q + 1'b1;
                    if (last_beat) state_d = RESP;
                end
            end
            RESP: begin
                bready = 1'b1;
                if (bvalid) begin
                    wb_done = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef CACHE_AXI_WB_ERR_EN
    always_ff @(posedge clk) begin
        if (rst)
            wb_err <= 1'b0;
        else if ((state_q == RESP) && bvalid && bresp[1])
            wb_err <= 1'b1;
    end
`endif

    assign wb_busy = (state_q != IDLE);
    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = 8'(LINE_WORDS - 1);
    assign awsize  = 3'd2;
    assign awburst = 2'd1;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = AXI_ID;
    assign wdata   = buf_q[beat_q[IW-1:0]];
    assign wstrb   = 4'hf;
    assign wlast   = (state_q == DATA) && last_beat;

    assign unused_inputs = ^{bid, bresp, wb_addr[OFS-1:0]};

endmodule

// File: tb/tb_cache_axi_winterface.sv
// Self-checking bench for cache_axi_winterface: W-beat scoreboard plus per-scenario tasks.
// Build with CACHE_AXI_WB_ERR_EN defined to also exercise the sticky error output.
module tb_cache_axi_winterface;
    localparam int LW = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          wb_addr;
    logic [LW*32-1:0]     wb_line;
    logic                 wb_req;
    logic                 wb_ack, wb_busy, wb_done;
    logic [3:0]           awid;
    logic [31:0]          awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst, awlock;
    logic [3:0]           awcache;
    logic [2:0]           awprot;
    logic                 awvalid, awready;
    logic [3:0]           wid;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wlast, wvalid, wready;
    logic [3:0]           bid;
    logic [1:0]           bresp;
    logic                 bvalid, bready;
`ifdef CACHE_AXI_WB_ERR_EN
    logic                 wb_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cache_axi_winterface #(.LINE_WORDS(LW), .AXI_ID(4'd1)) dut (
        .clk(clk), .rst(rst),
        .wb_addr(wb_addr), .wb_line(wb_line), .wb_req(wb_req),
        .wb_ack(wb_ack), .wb_busy(wb_busy), .wb_done(wb_done),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
`ifdef CACHE_AXI_WB_ERR_EN
        , .wb_err(wb_err)
`endif
    );

    // One complete writeback; ends at the negedge of the B handshake cycle.
    task automatic do_burst(input logic [31:0] addr, input logic [31:0] base,
                            input int aw_stall, input bit w_toggle, input int b_delay,
                            input logic [1:0] resp, input bit hold_req,
                            output int first_w, output int last_w);
        int cyc = 0, aw_wait = 0, bw = 0, beats = 0;
        bit aw_done = 0, done = 0, wtog = 1;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:6], 6'b0};
        first_w = -1;
        last_w  = -1;
        @(negedge clk);
        bvalid = 0; bresp = 2'b00; awready = 0; wready = 0;
        wb_addr = addr;
        for (int i = 0; i < LW; i++) begin
            wb_line[32*i +: 32] = base + i;
            exp_q.push_back(base + i);
        end
        wb_req = 1;
        #1;
        n_tests++;
        if ({wb_ack, wb_busy, wb_done} !== 3'b100) begin
            n_fail++;
            $display("FAIL accept: ack/busy/done got %b expected 100", {wb_ack, wb_busy, wb_done});
        end
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
            wb_req  = 0;
            wb_addr = 32'hDEAD_BEEF;
            wb_line = '1;
            if (!aw_done) begin
                awready = (aw_wait >= aw_stall);
                aw_wait++;
                #1;
                n_tests++;
                if ({awvalid, wvalid, wb_busy, wb_ack} !== 4'b1010 || awaddr !== exp_addr) begin
                    n_fail++;
                    $display("FAIL aw_phase cyc %0d: awv/wv/busy/ack %b addr %h expected 1010 addr %h",
                             cyc, {awvalid, wvalid, wb_busy, wb_ack}, awaddr, exp_addr);
                end
                n_tests++;
                if (awlen !== 8'd15 || awid !== 4'd1 || awsize !== 3'd2 || awburst !== 2'd1 ||
                    awlock !== 2'd0 || awcache !== 4'd0 || awprot !== 3'd0) begin
                    n_fail++;
                    $display("FAIL aw_fields: len %0d id %0d size %0d burst %0d expected 15 1 2 1",
                             awlen, awid, awsize, awburst);
                end
                if (awready) aw_done = 1;
            end else if (beats < LW) begin
                awready = 0;
                wready  = w_toggle ? wtog : 1'b1;
                #1;
                n_tests++;
                if ({wvalid, awvalid, wstrb, wid} !== {1'b1, 1'b0, 4'hf, 4'd1}) begin
                    n_fail++;
                    $display("FAIL w_ctrl cyc %0d: wvalid %b awvalid %b strb %h wid %0d expected 1 0 f 1",
                             cyc, wvalid, awvalid, wstrb, wid);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL w_data: got %h but scoreboard empty", wdata);
                end else if (wdata !== exp_q[0] || wlast !== (beats == LW - 1)) begin
                    n_fail++;
                    $display("FAIL w_data beat %0d: got %h last %b expected %h last %b",
                             beats, wdata, wlast, exp_q[0], (beats == LW - 1));
                end
                if (wready) begin
                    if (beats == 0) first_w = cyc;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    beats++;
                    if (beats == LW) last_w = cyc;
                end
                if (w_toggle) wtog = !wtog;
            end else begin
                wready = 0;
                wb_req = hold_req;
                bvalid = (bw >= b_delay);
                bresp  = resp;
                bw++;
                #1;
                n_tests++;
                if ({bready, wvalid, wb_busy, wb_ack, wb_done} !== {3'b101, 1'b0, bvalid}) begin
                    n_fail++;
                    $display("FAIL b_phase cyc %0d: bready/wv/busy/ack/done %b expected %b",
                             cyc, {bready, wvalid, wb_busy, wb_ack, wb_done}, {4'b1010, bvalid});
                end
                if (bvalid) done = 1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL burst_timeout: got no B handshake within 300 cycles, required one");
        end
    endtask

    task automatic idle_after(input string name);
        @(negedge clk);
        bvalid = 0; wb_req = 0; awready = 0; wready = 0;
        #1;
        n_tests++;
        if ({wb_done, wb_busy, awvalid, wvalid, bready} !== 5'b0) begin
            n_fail++;
            $display("FAIL %s idle: done/busy/awv/wv/bready %b expected 00000", name,
                     {wb_done, wb_busy, awvalid, wvalid, bready});
        end
    endtask

    task automatic test_reset();
        rst = 1; wb_req = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'd3;
        wb_addr = 0; wb_line = '0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if ({awvalid, wvalid, bready, wb_done, wb_busy, wb_ack} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset: outputs %b expected 000000",
                     {awvalid, wvalid, bready, wb_done, wb_busy, wb_ack});
        end
        rst = 0;
    endtask

    task automatic test_single();
        int f, l;
        do_burst(32'h1000_047C, 32'hA0, 0, 0, 0, 2'b00, 0, f, l);
        n_tests++;
        if (f != 2 || l != LW + 1) begin
            n_fail++;
            $display("FAIL single_latency: first %0d last %0d expected 2 %0d", f, l, LW + 1);
        end
        idle_after("single");
    endtask

    task automatic test_aw_backpressure();
        int f, l, aw_hs;
        do_burst(32'h2000_0000, 32'h1100, 5, 0, 2, 2'b00, 0, f, l);
        aw_hs = 6;
        n_tests++;
        if (f != aw_hs + 1) begin
            n_fail++;
            $display("FAIL aw_bp_first_w: got cycle %0d expected %0d", f, aw_hs + 1);
        end
        idle_after("aw_bp");
    endtask

    task automatic test_w_backpressure();
        int f, l;
        do_burst(32'h3000_0FC4, 32'h5500, 0, 1, 1, 2'b00, 0, f, l);
        n_tests++;
        if (l - f != 2 * (LW - 1) || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL w_bp_span: got span %0d left %0d expected %0d 0", l - f, exp_q.size(),
                     2 * (LW - 1));
        end
    endtask

    task automatic test_back_to_back();
        int f, l;
        do_burst(32'h4000_0040, 32'h7700, 0, 0, 9, 2'b00, 1, f, l);
        do_burst(32'h4000_0080, 32'h8800, 0, 0, 0, 2'b00, 0, f, l);
        n_tests++;
        if (f != 2) begin
            n_fail++;
            $display("FAIL b2b_first_w: got cycle %0d expected 2", f);
        end
        idle_after("b2b");
    endtask

    task automatic test_reset_mid();
        int f, l;
        @(negedge clk);
        wb_addr = 32'h5000_0000;
        for (int i = 0; i < LW; i++) wb_line[32*i +: 32] = 32'hC0 + i;
        wb_req = 1; awready = 1; wready = 1; bvalid = 0;
        @(negedge clk);
        wb_req = 0;
        repeat (8) @(negedge clk);
        #1;
        n_tests++;
        if (wvalid !== 1'b1 || wdata !== 32'hC7) begin
            n_fail++;
            $display("FAIL rst_mid_pre: wvalid %b wdata %h expected 1 000000c7", wvalid, wdata);
        end
        rst = 1;
        @(negedge clk);
        #1;
        n_tests++;
        if ({awvalid, wvalid, bready, wb_busy} !== 4'b0) begin
            n_fail++;
            $display("FAIL rst_mid: awv/wv/bready/busy %b expected 0000", {awvalid, wvalid, bready, wb_busy});
        end
        rst = 0; awready = 0; wready = 0;
        exp_q.delete();
        do_burst(32'h5000_0100, 32'hE0, 0, 0, 0, 2'b00, 0, f, l);
        idle_after("rst_mid_fresh");
    endtask

`ifdef CACHE_AXI_WB_ERR_EN
    task automatic test_err();
        int f, l;
        n_tests++;
        if (wb_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_init: got %b expected 0", wb_err);
        end
        do_burst(32'h6000_0000, 32'h10, 0, 0, 0, 2'b10, 0, f, l);
        idle_after("err");
        n_tests++;
        if (wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_set: got %b expected 1", wb_err);
        end
        do_burst(32'h6000_0040, 32'h20, 0, 0, 0, 2'b00, 0, f, l);
        idle_after("err_okay");
        n_tests++;
        if (wb_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got %b expected 1", wb_err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_aw_backpressure();
        test_w_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef CACHE_AXI_WB_ERR_EN
        test_err();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
